lock_controller: RTL and testbench

//  Sequencer for the digital lock. Collects debounced digits from the keypad scanner,

---
 rtl/lock_controller.sv | 154 +++++++++++++++
 tb/tb_lock_controller.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_controller.sv
// Keypad lock sequencer: gathers digits, checks them against the stored code, and
// handles the blink handshake, unlock hold, failure counting and lockout.
`default_nettype none

module lock_controller #(
    parameter int          CODE_LEN       = 4,
    parameter logic [31:0] CODE           = 32'h00001234,
    parameter int          MAX_TRIES      = 3,
    parameter logic [23:0] UNLOCK_CYCLES  = 24'd12000000,
    parameter logic [27:0] LOCKOUT_CYCLES = 28'd120000000,
    parameter logic [27:0] ENTRY_TIMEOUT  = 28'd60000000
) (
    input  logic       hwclk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       blink_done,
    output logic       blink_start,
    output logic       blink_type,
    output logic       unlocked,
    output logic       locked_out,
    output logic [3:0] digit_count,
    output logic [3:0] fail_count
);

    localparam int          BUF_W       = 4 * CODE_LEN;
    localparam logic [3:0]  CODE_LEN_W  = 4'(CODE_LEN);
    localparam logic [3:0]  MAX_TRIES_W = 4'(MAX_TRIES);
    localparam logic [27:0] UNLOCK_LAST = {4'd0, UNLOCK_CYCLES} - 28'd1;
    localparam logic [27:0] LOCKOUT_LAST = LOCKOUT_CYCLES - 28'd1;
    localparam logic [27:0] ENTRY_LAST  = ENTRY_TIMEOUT - 28'd1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_GRANT   = 3'd3,
        S_DENY    = 3'd4,
        S_LOCKOUT = 3'd5
    } state_t;

    state_t             state, state_n;
    logic [BUF_W-1:0]   digit_buf, digit_buf_n;
    logic [3:0]         digit_count_n, fail_count_n;
    logic [27:0]        timer, timer_n;
    logic               blink_start_n;
    logic               is_digit;

    assign is_digit = key_valid && (key_code != 4'd0) && (key_code <= 4'd9);

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            digit_buf   <= '0;
            digit_count <= 4'd0;
            fail_count  <= 4'd0;
            timer       <= 28'd0;
            blink_start <= 1'b0;
        end else begin
            state       <= state_n;
            digit_buf   <= digit_buf_n;
            digit_count <= digit_count_n;
            fail_count  <= fail_count_n;
            timer       <= timer_n;
            blink_start <= blink_start_n;
        end
    end

    always_comb begin
        state_n       = state;
        digit_buf_n   = digit_buf;
        digit_count_n = digit_count;
        fail_count_n  = fail_count;
        timer_n       = timer;
        blink_start_n = blink_start && !blink_done;
        unlocked      = 1'b0;
        locked_out    = 1'b0;
        blink_type    = 1'b0;

        case (state)
            S_IDLE: begin
                timer_n = 28'd0;
                if (is_digit) begin
                    digit_buf_n   = BUF_W'({digit_buf, key_code});
                    digit_count_n = 4'd1;
                    state_n       = (CODE_LEN == 1) ? S_CHECK : S_ENTRY;
                end
            end
            S_ENTRY: begin
                // A full buffer waits one cycle here so CHECK follows the last digit by one edge.
                if (digit_count == CODE_LEN_W) begin
                    state_n = S_CHECK;
                    timer_n = 28'd0;
                end else if (is_digit) begin
                    digit_buf_n   = BUF_W'({digit_buf, key_code});
                    digit_count_n = digit_count + 4'd1;
                    timer_n       = 28'd0;
                end else if (timer == ENTRY_LAST) begin
                    digit_buf_n   = '0;
                    digit_count_n = 4'd0;
                    timer_n       = 28'd0;
                    state_n       = S_IDLE;
                end else begin
                    timer_n = timer + 28'd1;
                end
            end
            S_CHECK: begin
                digit_count_n = 4'd0;
                digit_buf_n   = '0;
                timer_n       = 28'd0;
                blink_start_n = 1'b1;
                if (digit_buf == CODE[BUF_W-1:0]) begin
                    fail_count_n = 4'd0;
                    state_n      = S_GRANT;
                end else begin
                    fail_count_n = (fail_count == 4'hF) ? 4'hF : fail_count + 4'd1;
                    state_n      = S_DENY;
                end
            end
            S_GRANT: begin
                unlocked   = 1'b1;
                blink_type = 1'b1;
                if ((!blink_start || blink_done) && (timer == UNLOCK_LAST)) begin
                    timer_n = 28'd0;
                    state_n = S_IDLE;
                end else if (timer != UNLOCK_LAST) begin
                    timer_n = timer + 28'd1;
                end
            end
            S_DENY: begin
                timer_n = 28'd0;
                if (!blink_start || blink_done) begin
                    state_n = (fail_count >= MAX_TRIES_W) ? S_LOCKOUT : S_IDLE;
                end
            end
            S_LOCKOUT: begin
                locked_out = 1'b1;
                if (timer == LOCKOUT_LAST) begin
                    timer_n      = 28'd0;
                    fail_count_n = 4'd0;
                    state_n      = S_IDLE;
                end else begin
                    timer_n = timer + 28'd1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_lock_controller.sv
// Scenario bench for lock_controller: blink results are queued when a code is entered
// and checked by a monitor when blink_start rises.
`default_nettype none

module tb_lock_controller;

    logic       hwclk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       blink_done = 1'b0;
    logic       blink_start, blink_type, unlocked, locked_out;
    logic [3:0] digit_count, fail_count;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];
    logic [4:0] exp_item;
    logic       prev_bs = 1'b0;

    lock_controller #(
        .CODE_LEN(4), .CODE(32'h1234), .MAX_TRIES(3),
        .UNLOCK_CYCLES(24'd20), .LOCKOUT_CYCLES(28'd50), .ENTRY_TIMEOUT(28'd30)
    ) dut (
        .hwclk(hwclk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .blink_done(blink_done), .blink_start(blink_start), .blink_type(blink_type),
        .unlocked(unlocked), .locked_out(locked_out),
        .digit_count(digit_count), .fail_count(fail_count)
    );

    always #5 hwclk = ~hwclk;

    // Scoreboard side: each blink request must match the oldest queued {type, fail_count}.
    always @(negedge hwclk) begin
        if (blink_start && !prev_bs) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL blink_unexpected: got type=%0d fail=%0d, expected no request", blink_type, fail_count);
            end else begin
                exp_item = exp_q.pop_front();
                if ({blink_type, fail_count} !== exp_item) begin
                    errors++;
                    $display("FAIL blink_result: got type=%0d fail=%0d, expected type=%0d fail=%0d",
                             blink_type, fail_count, exp_item[4], exp_item[3:0]);
                end
            end
        end
        prev_bs = blink_start;
    end

    task automatic press(input logic [3:0] k);
        @(negedge hwclk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge hwclk);
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    task automatic enter_code(input logic [15:0] code, input logic t, input logic [3:0] f);
        exp_q.push_back({t, f});
        for (int i = 3; i >= 0; i--) press(code[4*i +: 4]);
    endtask

    task automatic wait_start(output int lat);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge hwclk);
            if (blink_start) begin
                lat = i + 1;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL blink_timeout: blink_start still 0 after 10 cycles, expected 1");
        end
    endtask

    task automatic ack_blink();
        blink_done = 1'b1;
        @(negedge hwclk);
        blink_done = 1'b0;
    endtask

    task automatic finish_grant();
        int n;
        ack_blink();
        n = 0;
        while (unlocked && n < 40) begin
            @(negedge hwclk);
            n++;
        end
        checks++;
        if (unlocked !== 1'b0) begin
            errors++;
            $display("FAIL grant_exit: unlocked=%0d after 40 cycles, expected 0", unlocked);
        end
    endtask

    task automatic apply_reset();
        @(negedge hwclk);
        rst = 1'b1;
        key_valid = 1'b0;
        blink_done = 1'b0;
        @(negedge hwclk);
        @(negedge hwclk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge hwclk);
        @(negedge hwclk);
        checks++;
        if ({blink_start, blink_type, unlocked, locked_out, digit_count, fail_count} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs: got bs=%0d bt=%0d un=%0d lo=%0d dc=%0d fc=%0d, expected all 0",
                     blink_start, blink_type, unlocked, locked_out, digit_count, fail_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_grant();
        int lat, cnt;
        enter_code(16'h1234, 1'b1, 4'd0);
        wait_start(lat);
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL grant_latency: got %0d cycles, expected 2", lat);
        end
        checks++;
        if (unlocked !== 1'b1) begin
            errors++;
            $display("FAIL grant_unlocked: got %0d, expected 1", unlocked);
        end
        cnt = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge hwclk);
            if (unlocked) cnt++;
        end
        ack_blink();
        if (unlocked) cnt++;
        checks++;
        if (blink_start !== 1'b0) begin
            errors++;
            $display("FAIL grant_blink_drop: got blink_start=%0d, expected 0", blink_start);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge hwclk);
            if (!unlocked) break;
            cnt++;
        end
        checks++;
        if (cnt != 20) begin
            errors++;
            $display("FAIL grant_hold: unlocked for %0d cycles, expected 20", cnt);
        end
    endtask

    task automatic test_deny();
        int lat;
        enter_code(16'h1235, 1'b0, 4'd1);
        wait_start(lat);
        ack_blink();
        checks++;
        if ({blink_start, unlocked, locked_out, fail_count} !== {3'b000, 4'd1}) begin
            errors++;
            $display("FAIL deny_after: got bs=%0d un=%0d lo=%0d fc=%0d, expected 0 0 0 1",
                     blink_start, unlocked, locked_out, fail_count);
        end
    endtask

    task automatic test_lockout();
        int lat, cnt;
        apply_reset();
        for (int k = 1; k <= 3; k++) begin
            enter_code(16'h9999, 1'b0, 4'(k));
            wait_start(lat);
            ack_blink();
        end
        checks++;
        if ({locked_out, fail_count} !== {1'b1, 4'd3}) begin
            errors++;
            $display("FAIL lockout_entry: got lo=%0d fc=%0d, expected 1 3", locked_out, fail_count);
        end
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (!locked_out) break;
            cnt++;
            key_valid = (i == 10 || i == 11);
            key_code  = 4'd1;
            @(negedge hwclk);
        end
        key_valid = 1'b0;
        checks++;
        if (cnt != 50) begin
            errors++;
            $display("FAIL lockout_len: locked_out for %0d cycles, expected 50", cnt);
        end
        checks++;
        if ({digit_count, fail_count} !== 8'd0) begin
            errors++;
            $display("FAIL lockout_exit: got dc=%0d fc=%0d, expected 0 0", digit_count, fail_count);
        end
        enter_code(16'h1234, 1'b1, 4'd0);
        wait_start(lat);
        finish_grant();
    endtask

    task automatic test_timeout();
        int lat;
        enter_code(16'h1111, 1'b0, 4'd1);
        wait_start(lat);
        ack_blink();
        press(4'd1);
        press(4'd2);
        repeat (29) @(negedge hwclk);
        checks++;
        if (digit_count !== 4'd2) begin
            errors++;
            $display("FAIL timeout_early: got dc=%0d, expected 2", digit_count);
        end
        @(negedge hwclk);
        checks++;
        if ({digit_count, fail_count} !== {4'd0, 4'd1}) begin
            errors++;
            $display("FAIL timeout_clear: got dc=%0d fc=%0d, expected 0 1", digit_count, fail_count);
        end
        enter_code(16'h1234, 1'b1, 4'd0);
        wait_start(lat);
        finish_grant();
    endtask

    task automatic test_invalid_keys();
        int lat;
        press(4'd1);
        press(4'd2);
        press(4'd0);
        press(4'hB);
        checks++;
        if (digit_count !== 4'd2) begin
            errors++;
            $display("FAIL invalid_keys: got dc=%0d, expected 2", digit_count);
        end
        exp_q.push_back({1'b1, 4'd0});
        press(4'd3);
        press(4'd4);
        wait_start(lat);
        press(4'd5);
        press(4'd6);
        checks++;
        if ({digit_count, unlocked} !== {4'd0, 1'b1}) begin
            errors++;
            $display("FAIL grant_keys: got dc=%0d un=%0d, expected 0 1", digit_count, unlocked);
        end
        finish_grant();
        checks++;
        if (digit_count !== 4'd0) begin
            errors++;
            $display("FAIL grant_keys_after: got dc=%0d, expected 0", digit_count);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        enter_code(16'h1234, 1'b1, 4'd0);
        wait_start(lat);
        rst = 1'b1;
        #1;
        checks++;
        if ({unlocked, blink_start} !== 2'b00) begin
            errors++;
            $display("FAIL reset_grant: got un=%0d bs=%0d, expected 0 0", unlocked, blink_start);
        end
        @(negedge hwclk);
        rst = 1'b0;
        enter_code(16'h4321, 1'b0, 4'd1);
        wait_start(lat);
        ack_blink();
        press(4'd7);
        rst = 1'b1;
        #1;
        checks++;
        if ({fail_count, digit_count, unlocked, blink_start} !== 10'd0) begin
            errors++;
            $display("FAIL reset_clear: got fc=%0d dc=%0d un=%0d bs=%0d, expected all 0",
                     fail_count, digit_count, unlocked, blink_start);
        end
        @(negedge hwclk);
        rst = 1'b0;
        @(negedge hwclk);
    endtask

    initial begin
        test_reset();
        test_grant();
        test_deny();
        test_lockout();
        test_timeout();
        test_invalid_keys();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d blink results outstanding, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
